// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle signed restoring divider, one quotient bit per cycle
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] mb_q;
    logic [WIDTH-1:0] a_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dz_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             busy_q;
    logic             done_q;
    logic             divzero_q;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH:0]   p_d;
    logic [WIDTH-1:0] d_d;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes, one restoring step, and sign/zero fix-up of the final result
    always_comb begin
        abs_a = A[WIDTH-1] ? (ZERO - A) : A;
        abs_b = B[WIDTH-1] ? (ZERO - B) : B;
        // Shifted partial remainder; the dropped P MSB is always zero since P < |B|,
        // but it still participates in the compare so the full P width is honoured.
        p_sh  = {p_q[WIDTH-1:0], d_q[WIDTH-1]};
        ge    = ({p_q, d_q[WIDTH-1]} >= {2'b00, mb_q});
        t     = p_sh - {1'b0, mb_q};
        if (ge) begin
            p_d = t;
            d_d = {d_q[WIDTH-2:0], 1'b1};
        end else begin
            p_d = p_sh;
            d_d = {d_q[WIDTH-2:0], 1'b0};
        end
        q_fix = qneg_q ? (ZERO - d_q) : d_q;
        r_fix = rneg_q ? (ZERO - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
        if (dz_q) begin
            q_fix = ONES;
            r_fix = a_q;
        end
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            d_q       <= '0;
            mb_q      <= '0;
            a_q       <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        p_q     <= '0;
                        d_q     <= abs_a;
                        mb_q    <= abs_b;
                        a_q     <= A;
                        qneg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                        rneg_q  <= A[WIDTH-1];
                        dz_q    <= (B == ZERO);
                    end
                end
                CALC: begin
                    p_q <= p_d;
                    d_q <= d_d;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                FIX: begin
                    q_q       <= q_fix;
                    r_q       <= r_fix;
                    divzero_q <= dz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q       = q_q;
    assign R       = r_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = divzero_q;

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - table-driven, scoreboarded bench for seq_div
module tb_seq_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         nReset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    seq_div #(.WIDTH(W)) dut (
        .clk    (clk),
        .nReset (nReset),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Q      (Q),
        .R      (R),
        .Busy   (Busy),
        .Done   (Done),
        .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ai;
        int   bi;
        int   qi;
        int   ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            qi   = ai / bi;
            ri   = ai % bi;
            e.q  = qi[W-1:0];
            e.r  = ri[W-1:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every Done pops one expectation
    always @(negedge clk) begin
        if (nReset && Done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got Done with empty scoreboard expected none");
            end else begin
                e = sb.pop_front();
                chk("sb_Q", 32'(Q), 32'(e.q));
                chk("sb_R", 32'(R), 32'(e.r));
                chk("sb_DivZero", 32'(DivZero), 32'(e.dz));
            end
        end
    end

    // Drive Start for one accepted edge and record the expectation
    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q = q;
        e.r = r;
        e.dz = dz;
        Start = 1'b1;
        A = a;
        B = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        Start = 1'b0;
        A = $urandom_range(0, 255);
        B = $urandom_range(0, 255);
    endtask

    // Wait for Done, checking latency and Busy length; called #1 after the accept edge
    task automatic wait_done(input string nm);
        int cyc;
        int nb;
        cyc = 0;
        nb  = 0;
        while (!Done && cyc < 30) begin
            if (Busy) nb++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'd9);
        chk({nm, "_busy_cycles"}, 32'(nb), 32'd9);
        chk({nm, "_busy_low_at_done"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        exp_t e;
        int   d0;
        logic [W-1:0] q0;
        logic [W-1:0] r0;

        vecs.push_back('{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0});
        vecs.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});
        vecs.push_back('{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0});
        vecs.push_back('{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0});
        vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0});
        vecs.push_back('{8'h00, 8'h05, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h32, 8'h00, 8'hFF, 8'h32, 1'b1});
        vecs.push_back('{8'hFD, 8'h00, 8'hFF, 8'hFD, 1'b1});
        vecs.push_back('{8'h09, 8'h03, 8'h03, 8'h00, 1'b0});
        vecs.push_back('{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0});
        for (int i = 0; i < 6; i++) begin
            v.a = $urandom_range(0, 255);
            v.b = $urandom_range(0, 255);
            e = model(v.a, v.b);
            v.q = e.q;
            v.r = e.r;
            v.dz = e.dz;
            vecs.push_back(v);
        end

        nReset = 1'b0;
        Start  = 1'b0;
        A      = '0;
        B      = '0;
        #1;
        chk("reset_Q", 32'(Q), 32'd0);
        chk("reset_R", 32'(R), 32'd0);
        chk("reset_Busy", 32'(Busy), 32'd0);
        chk("reset_Done", 32'(Done), 32'd0);
        chk("reset_DivZero", 32'(DivZero), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nReset = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, with a hold check one cycle after each Done
        foreach (vecs[i]) begin
            start_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
            wait_done($sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_one_cycle", i), 32'(Done), 32'd0);
            chk($sformatf("vec%0d_hold_Q", i), 32'(Q), 32'(vecs[i].q));
            chk($sformatf("vec%0d_hold_DivZero", i), 32'(DivZero), 32'(vecs[i].dz));
        end

        // Start pulses while busy are ignored
        d0 = n_done;
        start_div(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            Start = (c == 3 || c == 5);
            if (Start) begin
                A = 8'h01;
                B = 8'h01;
            end
        end
        Start = 1'b0;
        chk("busy_start_done_count", 32'(n_done - d0), 32'd1);
        chk("busy_start_Q", 32'(Q), 32'h0E);
        chk("busy_start_R", 32'(R), 32'h02);
        chk("busy_start_sb_empty", 32'(sb.size()), 32'd0);

        // Back-to-back: Start held during the Done cycle
        start_div(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);
        wait_done("b2b_first");
        start_div(8'd20, 8'd6, 8'h03, 8'h02, 1'b0);
        wait_done("b2b_second");
        @(posedge clk);
        #1;

        // Reset mid-operation aborts with no Done
        d0 = n_done;
        start_div(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        nReset = 1'b0;
        #1;
        q0 = Q;
        r0 = R;
        chk("rst_mid_Busy", 32'(Busy), 32'd0);
        chk("rst_mid_Done", 32'(Done), 32'd0);
        chk("rst_mid_Q", 32'(q0), 32'd0);
        chk("rst_mid_R", 32'(r0), 32'd0);
        chk("rst_mid_DivZero", 32'(DivZero), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        nReset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_done", 32'(n_done - d0), 32'd0);
        start_div(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);
        wait_done("after_reset");
        @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle signed integer divider for the picoMips datapath. It is the inverse counterpart to the combinational `mult`/mux multiplier cells. It accepts an 8-bit signed dividend and divisor on a start pulse and runs a restoring shift-subtract loop, one quotient bit per cycle. It returns the quotient and remainder, truncated toward zero, with a one-cycle done strobe. The ALU stalls on `Busy` and captures results on `Done`.

## Interface
- `WIDTH`, default 8: operand/result width in bits; iteration count = `WIDTH`.
- `clk`  in  1  system clock; all state changes on rising edge.
- `nReset`  in  1  reset, asynchronous assert, active-low; one clock, no other reset.
- `Start`  in  1  request; sampled only in IDLE.
- `A`  in  WIDTH  signed dividend; latched on accepted `Start`.
- `B`  in  WIDTH  signed divisor; latched on accepted `Start`.
- `Q`  out  WIDTH  signed quotient; registered.
- `R`  out  WIDTH  signed remainder; registered.
- `Busy`  out  1  high while a division is in progress.
- `Done`  out  1  one-cycle strobe: `Q`/`R`/`DivZero` are valid from this cycle.
- `DivZero`  out  1  last completed division had `B == 0`; registered.

## Operation
- States: IDLE, CALC, FIX.
  - IDLE: `Start=1` → latch operands, go to CALC.
  - CALC: runs exactly `WIDTH` cycles, counted by a `$clog2(WIDTH+1)`-bit counter, then goes to FIX.
  - FIX: writes outputs, then returns to IDLE.
- On accept, the block latches:
  - `|A|` and `|B|` as `WIDTH`-bit unsigned magnitudes, so -128 becomes 0x80 unsigned.
  - Quotient sign `qNeg = A[MSB] ^ B[MSB]`.
  - Remainder sign `rNeg = A[MSB]`.
  - Divide-by-zero flag `dz = (B == 0)`.
- CALC iteration (unsigned restoring):
  - Partial remainder `P` is `WIDTH+1` bits.
  - Shift `{P, D}` left by 1 and compute `T = P - |B|`.
  - If `T >= 0`: `P = T` and the D LSB becomes 1. Otherwise the D LSB is 0.
- FIX:
  - `Q = qNeg ? -D : D` and `R = rNeg ? -P[WIDTH-1:0] : P[WIDTH-1:0]`. Negation is two's complement, truncated to `WIDTH`.
  - If `dz`: force `Q = all ones` (-1) and `R = A` (original signed dividend), and set `DivZero=1`. Otherwise `DivZero=0`.
- Overflow case `A = -2^(WIDTH-1)`, `B = -1`: needs no special logic. The result is `Q = 0x80`, `R = 0`, `DivZero=0`.
- `Start` asserted while `Busy=1` is ignored, and the latched operands do not change. `A`/`B` may change freely after the accept edge.
- `Q`, `R` and `DivZero` hold their values until the next FIX cycle.

## Timing
- Reset values (`nReset` low, immediately and asynchronously): state = IDLE, `Q=0`, `R=0`, `Busy=0`, `Done=0`, `DivZero=0`, counter = 0, internal operand registers = 0.
- Let edge k be the edge that samples `Start=1` in IDLE.
  - `Busy=1` from after edge k.
  - CALC occupies cycles k+1 .. k+WIDTH.
  - FIX is the cycle after CALC completes. On the following edge (k+WIDTH+1, edge k+9 for WIDTH=8), `Q`/`R`/`DivZero` update, `Done=1`, `Busy=0`, and the state returns to IDLE.
- `Done` is high for exactly one cycle.
- Latency from the `Start` edge to results valid is `WIDTH+1` cycles (9 for WIDTH=8), independent of operand values, including `B==0`.
- Back-to-back: `Start=1` during the `Done` cycle is accepted, because the state is IDLE. Throughput is one division per `WIDTH+1` cycles.
- Reset during CALC or FIX aborts the operation. `Done` does not pulse, and outputs return to reset values. The first `Start` after `nReset` deasserts is accepted normally.

## Test plan
- `A=100 (0x64)`, `B=7` → 9 cycles after the `Start` edge: `Done=1`, `Q=0x0E`, `R=0x02`, `DivZero=0`. `Busy` is high for exactly 9 cycles.
- Sign combinations with magnitudes 100/7:
  - `A=-100 (0x9C)`, `B=7` → `Q=0xF2`, `R=0xFE`.
  - `A=100`, `B=-7 (0xF9)` → `Q=0xF2`, `R=0x02`.
  - `A=-100`, `B=-7` → `Q=0x0E`, `R=0xFE`.
- Edge values:
  - `A=0x80`, `B=0xFF` → `Q=0x80`, `R=0x00`.
  - `A=0x80`, `B=0x01` → `Q=0x80`, `R=0`.
  - `A=0`, `B=5` → `Q=0`, `R=0`.
- Divide by zero: `A=50 (0x32)`, `B=0` → after 9 cycles `Q=0xFF`, `R=0x32`, `DivZero=1`. Then `A=-3`, `B=0` → `Q=0xFF`, `R=0xFD`. A following 9/3 → `DivZero=0`, `Q=3`, `R=0`.
- Handshake:
  - `Start` pulsed at cycles +3 and +5 during a busy 100/7 with `A`/`B` changed to 1/1 → result stays `Q=0x0E`, `R=0x02`, and only one `Done` occurs.
  - `Start` with 20/6 held during the `Done` cycle → second `Done` exactly 9 cycles later with `Q=3`, `R=2`.
- Reset mid-operation: assert `nReset` low 4 cycles into 100/7 → `Busy`, `Done`, `Q`, `R` and `DivZero` go to 0 asynchronously, with no `Done` pulse. After release, 100/7 completes normally in 9 cycles.
